// File: rtl/demux4_stream_if.sv
// rtl/demux4_stream_if.sv - stream and status bundle for the 1-to-4 stream demultiplexer
interface demux4_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_last;
  logic [1:0]       i_sel;
  logic             o_ready;

  logic [WIDTH-1:0] o_data_0;
  logic [WIDTH-1:0] o_data_1;
  logic [WIDTH-1:0] o_data_2;
  logic [WIDTH-1:0] o_data_3;
  logic [3:0]       o_valid;
  logic [3:0]       o_last;
  logic [3:0]       i_ready;

  logic             o_busy;
  logic [1:0]       o_cur_sel;
  logic [CNT_W-1:0] o_pkt_cnt_0;
  logic [CNT_W-1:0] o_pkt_cnt_1;
  logic [CNT_W-1:0] o_pkt_cnt_2;
  logic [CNT_W-1:0] o_pkt_cnt_3;

  // Upstream source plus the four downstream sinks
  modport master (
    output i_data, i_valid, i_last, i_sel, i_ready,
    input  o_ready, o_data_0, o_data_1, o_data_2, o_data_3,
    input  o_valid, o_last, o_busy, o_cur_sel,
    input  o_pkt_cnt_0, o_pkt_cnt_1, o_pkt_cnt_2, o_pkt_cnt_3
  );

  // Demultiplexer side
  modport slave (
    input  i_data, i_valid, i_last, i_sel, i_ready,
    output o_ready, o_data_0, o_data_1, o_data_2, o_data_3,
    output o_valid, o_last, o_busy, o_cur_sel,
    output o_pkt_cnt_0, o_pkt_cnt_1, o_pkt_cnt_2, o_pkt_cnt_3
  );
endinterface

// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - 1-to-4 packet stream demultiplexer with per-channel slots and packet counters
module demux4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  demux4_stream_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cur_sel;
  logic [1:0]       cur_sel_nxt;

  logic [1:0]       dest;
  logic             ready;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       drain;

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       last_q;
  logic [CNT_W-1:0] cnt_q  [4];

  // Destination is the live select between packets and the locked one inside a packet;
  // a slot can take a beat if it is empty or being drained this cycle
  always_comb begin
    dest   = (state == LOCKED) ? cur_sel : bus.i_sel;
    ready  = ~valid_q[dest] | bus.i_ready[dest];
    accept = bus.i_valid & ready;
    load   = accept ? (4'b0001 << dest) : 4'b0000;
    drain  = valid_q & bus.i_ready;
  end

  // Packet framing FSM: lock the destination on a non-last first beat, release on the last beat
  always_comb begin
    state_nxt   = state;
    cur_sel_nxt = cur_sel;
    case (state)
      IDLE: begin
        if (accept && !bus.i_last) begin
          state_nxt   = LOCKED;
          cur_sel_nxt = bus.i_sel;
        end
      end
      LOCKED: begin
        if (accept && bus.i_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and locked destination registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cur_sel <= 2'd0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_sel_nxt;
    end
  end

  // Output slots: a load wins over a drain so a same-cycle drain+reload leaves no bubble
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 4'b0000;
      last_q  <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= load | (valid_q & ~drain);
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.i_data;
          last_q[k] <= bus.i_last;
        end
      end
    end
  end

  // Completed-packet counters advance when a last beat leaves its slot; they wrap freely
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k] && last_q[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_data_0    = data_q[0];
  assign bus.o_data_1    = data_q[1];
  assign bus.o_data_2    = data_q[2];
  assign bus.o_data_3    = data_q[3];
  assign bus.o_valid     = valid_q;
  assign bus.o_last      = last_q;
  assign bus.o_busy      = (state == LOCKED);
  assign bus.o_cur_sel   = cur_sel;
  assign bus.o_pkt_cnt_0 = cnt_q[0];
  assign bus.o_pkt_cnt_1 = cnt_q[1];
  assign bus.o_pkt_cnt_2 = cnt_q[2];
  assign bus.o_pkt_cnt_3 = cnt_q[3];

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - directed self-checking bench for demux4_stream
module tb_demux4_stream;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux4_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux4_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic l);
    bus.i_data  = d;
    bus.i_sel   = s;
    bus.i_last  = l;
    bus.i_valid = 1'b1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  function automatic logic [7:0] data_of(input int k);
    case (k)
      0:       return bus.o_data_0;
      1:       return bus.o_data_1;
      2:       return bus.o_data_2;
      default: return bus.o_data_3;
    endcase
  endfunction

  function automatic logic [7:0] cnt_of(input int k);
    case (k)
      0:       return bus.o_pkt_cnt_0;
      1:       return bus.o_pkt_cnt_1;
      2:       return bus.o_pkt_cnt_2;
      default: return bus.o_pkt_cnt_3;
    endcase
  endfunction

  // Directed sequence
  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_sel   = 2'd0;
    bus.i_last  = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 4'hF;

    // Reset state
    tick();
    tick();
    chk("rst_valid", bus.o_valid, 4'b0000);
    chk("rst_last", bus.o_last, 4'b0000);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_cur_sel", bus.o_cur_sel, 2'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_data%0d", k), data_of(k), 8'h00);
      chk($sformatf("rst_cnt%0d", k), cnt_of(k), 8'h00);
    end
    rst_n = 1'b1;

    // Single-beat packets, one per cycle, to each channel
    for (int k = 0; k < 4; k++) begin
      drive(8'(10 + k), 2'(k), 1'b1);
      #1;
      chk($sformatf("single_ready%0d", k), bus.o_ready, 1'b1);
      tick();
      chk($sformatf("single_valid%0d", k), bus.o_valid, 4'b0001 << k);
      chk($sformatf("single_data%0d", k), data_of(k), 8'(10 + k));
      chk($sformatf("single_busy%0d", k), bus.o_busy, 1'b0);
    end
    idle();
    tick();
    chk("single_drained", bus.o_valid, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("single_cnt%0d", k), cnt_of(k), 8'd1);
    end

    // Packet lock: select changes after the first beat are ignored
    drive(8'hA0, 2'd2, 1'b0);
    tick();
    chk("lock_valid0", bus.o_valid, 4'b0100);
    chk("lock_data0", bus.o_data_2, 8'hA0);
    chk("lock_busy0", bus.o_busy, 1'b1);
    chk("lock_sel0", bus.o_cur_sel, 2'd2);
    drive(8'hA1, 2'd1, 1'b0);
    #1;
    chk("lock_ready1", bus.o_ready, 1'b1);
    tick();
    chk("lock_valid1", bus.o_valid, 4'b0100);
    chk("lock_data1", bus.o_data_2, 8'hA1);
    chk("lock_busy1", bus.o_busy, 1'b1);
    drive(8'hA2, 2'd1, 1'b1);
    tick();
    chk("lock_valid2", bus.o_valid, 4'b0100);
    chk("lock_data2", bus.o_data_2, 8'hA2);
    chk("lock_busy2", bus.o_busy, 1'b0);
    chk("lock_sel2", bus.o_cur_sel, 2'd2);
    idle();
    tick();
    chk("lock_drained", bus.o_valid, 4'b0000);
    chk("lock_cnt2", bus.o_pkt_cnt_2, 8'd2);
    chk("lock_cnt1", bus.o_pkt_cnt_1, 8'd1);

    // Backpressure on channel 0, then release with no bubble
    bus.i_ready = 4'b1110;
    drive(8'hB0, 2'd0, 1'b0);
    #1;
    chk("bp_ready0", bus.o_ready, 1'b1);
    tick();
    chk("bp_valid0", bus.o_valid, 4'b0001);
    chk("bp_data0", bus.o_data_0, 8'hB0);
    drive(8'hB1, 2'd0, 1'b1);
    #1;
    chk("bp_stall_ready", bus.o_ready, 1'b0);
    tick();
    chk("bp_hold_data", bus.o_data_0, 8'hB0);
    chk("bp_hold_ready", bus.o_ready, 1'b0);
    bus.i_ready = 4'hF;
    #1;
    chk("bp_release_ready", bus.o_ready, 1'b1);
    tick();
    chk("bp_valid1", bus.o_valid, 4'b0001);
    chk("bp_data1", bus.o_data_0, 8'hB1);
    chk("bp_busy1", bus.o_busy, 1'b0);
    chk("bp_cnt_mid", bus.o_pkt_cnt_0, 8'd1);
    idle();
    tick();
    chk("bp_drained", bus.o_valid, 4'b0000);
    chk("bp_cnt0", bus.o_pkt_cnt_0, 8'd2);

    // Channel 3 stalled while channel 1 streams at full rate
    bus.i_ready = 4'b0111;
    drive(8'hC3, 2'd3, 1'b1);
    tick();
    chk("ind_valid_c3", bus.o_valid, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'hD0 + i), 2'd1, (i == 2));
      #1;
      chk($sformatf("ind_ready%0d", i), bus.o_ready, 1'b1);
      tick();
      chk($sformatf("ind_valid%0d", i), bus.o_valid, 4'b1010);
      chk($sformatf("ind_data%0d", i), bus.o_data_1, 8'(8'hD0 + i));
    end
    idle();
    tick();
    chk("ind_c3_held", bus.o_valid, 4'b1000);
    chk("ind_c3_data", bus.o_data_3, 8'hC3);
    chk("ind_cnt1", bus.o_pkt_cnt_1, 8'd2);
    chk("ind_cnt3_wait", bus.o_pkt_cnt_3, 8'd1);
    bus.i_ready = 4'hF;
    tick();
    chk("ind_drained", bus.o_valid, 4'b0000);
    chk("ind_cnt3", bus.o_pkt_cnt_3, 8'd2);

    // Asynchronous reset in the middle of a packet
    drive(8'hE0, 2'd2, 1'b0);
    tick();
    chk("mid_busy", bus.o_busy, 1'b1);
    chk("mid_valid", bus.o_valid, 4'b0100);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.o_valid, 4'b0000);
    chk("mid_rst_busy", bus.o_busy, 1'b0);
    chk("mid_rst_sel", bus.o_cur_sel, 2'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_rst_cnt%0d", k), cnt_of(k), 8'd0);
    end
    tick();
    rst_n = 1'b1;
    drive(8'hF0, 2'd0, 1'b1);
    #1;
    chk("post_rst_ready", bus.o_ready, 1'b1);
    tick();
    chk("post_rst_valid", bus.o_valid, 4'b0001);
    chk("post_rst_data", bus.o_data_0, 8'hF0);
    chk("post_rst_busy", bus.o_busy, 1'b0);

    // Counter wrap: 254 more single-beat packets to channel 0 reach 255, one more wraps to 0
    for (int i = 0; i < 254; i++) begin
      drive(8'(i), 2'd0, 1'b1);
      tick();
    end
    idle();
    tick();
    chk("wrap_cnt255", bus.o_pkt_cnt_0, 8'd255);
    drive(8'h55, 2'd0, 1'b1);
    tick();
    idle();
    tick();
    chk("wrap_cnt0", bus.o_pkt_cnt_0, 8'd0);
    chk("wrap_cnt1", bus.o_pkt_cnt_1, 8'd0);
    chk("wrap_cnt2", bus.o_pkt_cnt_2, 8'd0);
    chk("wrap_cnt3", bus.o_pkt_cnt_3, 8'd0);
    chk("wrap_valid", bus.o_valid, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
